wx_sensor_conditioner: RTL and testbench

WX_SENSOR_CONDITIONER -- requirements
Module: wx_sensor_conditioner

---
 rtl/wx_sensor_conditioner.sv | 201 ++++++++++++++++++++
 tb/tb_wx_sensor_conditioner.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/wx_sensor_conditioner.sv
// rtl/wx_sensor_conditioner.sv - weather sensor conditioning: window averaging, debounce, persistence filter, staleness fault
module wx_sensor_conditioner #(
  parameter int TIMEOUT = 1000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       sample_valid,
  input  logic       raw_thunder,
  input  logic [5:0] raw_wind,
  input  logic [1:0] raw_visibility,
  input  logic [7:0] raw_temperature,
  output logic       thunderstorm,
  output logic [5:0] wind,
  output logic [1:0] visibility,
  output logic [7:0] temperature,
  output logic       out_valid,
  output logic       sensor_fault
);

  localparam int IW = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT - 1);
  localparam logic [IW-1:0] IDLE_MAX  = IW'(TIMEOUT);

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_RUN   = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  // Index 0 holds the newest accepted sample.
  logic [5:0] r_wwin [4];
  logic [7:0] r_twin [4];
  logic [1:0] r_fill;
  logic [IW-1:0] r_idle;

  logic [1:0] r_on_cnt;
  logic [1:0] r_off_cnt;
  logic       r_th_f;
  logic [1:0] r_vis_prev;
  logic       r_vis_have;
  logic [1:0] r_vis_f;

  logic       r_thunder;
  logic [5:0] r_wind;
  logic [1:0] r_vis;
  logic [7:0] r_temp;
  logic       r_out_valid;

  logic              w_idle_hit;
  logic              w_publish;
  logic              w_flush;
  logic [7:0]        w_wsum;
  logic signed [9:0] w_tsum;
  logic [1:0]        w_on_base;
  logic [1:0]        w_off_base;
  logic              w_vis_have_base;
  logic [1:0]        w_on_nxt;
  logic [1:0]        w_off_nxt;
  logic              w_th_nxt;
  logic [1:0]        w_vis_nxt;

  // A sample arriving on the would-be timeout cycle is not idle, so it always wins.
  assign w_idle_hit = !sample_valid && (r_idle == IDLE_LAST);

  // Averages use the window as it will be after this sample shifts in.
  assign w_wsum = {2'b00, raw_wind} + {2'b00, r_wwin[0]} + {2'b00, r_wwin[1]} + {2'b00, r_wwin[2]};
  assign w_tsum = {{2{raw_temperature[7]}}, raw_temperature} + {{2{r_twin[0][7]}}, r_twin[0]}
                + {{2{r_twin[1][7]}}, r_twin[1]} + {{2{r_twin[2][7]}}, r_twin[2]};

  // Leaving FAULT restarts the debounce/persistence runs from scratch; the sample is then applied.
  assign w_on_base       = w_flush ? 2'd0 : r_on_cnt;
  assign w_off_base      = w_flush ? 2'd0 : r_off_cnt;
  assign w_vis_have_base = w_flush ? 1'b0 : r_vis_have;

  assign w_on_nxt  = raw_thunder ? ((w_on_base == 2'd2) ? 2'd2 : w_on_base + 2'd1) : 2'd0;
  assign w_off_nxt = raw_thunder ? 2'd0 : ((w_off_base == 2'd3) ? 2'd3 : w_off_base + 2'd1);
  assign w_th_nxt  = (w_on_nxt == 2'd2) ? 1'b1 : ((w_off_nxt == 2'd3) ? 1'b0 : r_th_f);
  assign w_vis_nxt = (w_vis_have_base && (raw_visibility == r_vis_prev)) ? raw_visibility : r_vis_f;

  // Controller state register.
  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_FILL;
    else     r_state <= w_next;
  end

  // Controller next-state: fill to four samples, run, drop to FAULT on a stale stream.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FILL: begin
        if (sample_valid && (r_fill == 2'd3)) w_next = S_RUN;
        else if (w_idle_hit)                  w_next = S_FAULT;
      end
      S_RUN: begin
        if (w_idle_hit) w_next = S_FAULT;
      end
      S_FAULT: begin
        if (sample_valid) w_next = S_FILL;
      end
      default: w_next = S_FILL;
    endcase
  end

  // Controller outputs: when to publish and when to flush on recovery.
  always_comb begin
    w_publish = 1'b0;
    w_flush   = 1'b0;
    case (r_state)
      S_FILL:  w_publish = sample_valid && (r_fill == 2'd3);
      S_RUN:   w_publish = sample_valid;
      S_FAULT: w_flush   = sample_valid;
      default: begin
        w_publish = 1'b0;
        w_flush   = 1'b0;
      end
    endcase
  end

  // Sample window and fill count; a recovery sample becomes the only window entry.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < 4; i++) begin
        r_wwin[i] <= 6'd0;
        r_twin[i] <= 8'd0;
      end
      r_fill <= 2'd0;
    end else if (w_flush) begin
      r_wwin[0] <= raw_wind;
      r_twin[0] <= raw_temperature;
      for (int i = 1; i < 4; i++) begin
        r_wwin[i] <= 6'd0;
        r_twin[i] <= 8'd0;
      end
      r_fill <= 2'd1;
    end else if (sample_valid) begin
      r_wwin[0] <= raw_wind;
      r_twin[0] <= raw_temperature;
      for (int i = 1; i < 4; i++) begin
        r_wwin[i] <= r_wwin[i-1];
        r_twin[i] <= r_twin[i-1];
      end
      if (r_state == S_FILL) r_fill <= r_fill + 2'd1;
    end
  end

  // Staleness counter: cleared by samples, saturating on idle cycles.
  always_ff @(posedge CLK) begin
    if (RST)                   r_idle <= '0;
    else if (sample_valid)     r_idle <= '0;
    else if (r_idle != IDLE_MAX) r_idle <= r_idle + IW'(1);
  end

  // Thunder debounce and visibility persistence, advanced on accepted samples only.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_on_cnt   <= 2'd0;
      r_off_cnt  <= 2'd0;
      r_th_f     <= 1'b0;
      r_vis_prev <= 2'd0;
      r_vis_have <= 1'b0;
      r_vis_f    <= 2'd0;
    end else if (sample_valid) begin
      r_on_cnt   <= w_on_nxt;
      r_off_cnt  <= w_off_nxt;
      r_th_f     <= w_th_nxt;
      r_vis_prev <= raw_visibility;
      r_vis_have <= 1'b1;
      r_vis_f    <= w_vis_nxt;
    end
  end

  // Published outputs, loaded together on a publishing edge and held otherwise.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_thunder   <= 1'b0;
      r_wind      <= 6'd0;
      r_vis       <= 2'd0;
      r_temp      <= 8'd0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= w_publish;
      if (w_publish) begin
        r_thunder <= w_th_nxt;
        r_wind    <= 6'(w_wsum >> 2);
        r_vis     <= w_vis_nxt;
        r_temp    <= 8'(w_tsum >>> 2);
      end
    end
  end

  assign thunderstorm = r_thunder;
  assign wind         = r_wind;
  assign visibility   = r_vis;
  assign temperature  = r_temp;
  assign out_valid    = r_out_valid;
  assign sensor_fault = (r_state == S_FAULT);

endmodule

// File: tb/tb_wx_sensor_conditioner.sv
// tb/tb_wx_sensor_conditioner.sv - self-checking bench for wx_sensor_conditioner
module tb_wx_sensor_conditioner;
  localparam int TO = 8;

  logic       CLK = 1'b0;
  logic       RST;
  logic       sample_valid;
  logic       raw_thunder;
  logic [5:0] raw_wind;
  logic [1:0] raw_visibility;
  logic [7:0] raw_temperature;
  logic       thunderstorm;
  logic [5:0] wind;
  logic [1:0] visibility;
  logic [7:0] temperature;
  logic       out_valid;
  logic       sensor_fault;

  wx_sensor_conditioner #(.TIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST), .sample_valid(sample_valid), .raw_thunder(raw_thunder),
    .raw_wind(raw_wind), .raw_visibility(raw_visibility), .raw_temperature(raw_temperature),
    .thunderstorm(thunderstorm), .wind(wind), .visibility(visibility),
    .temperature(temperature), .out_valid(out_valid), .sensor_fault(sensor_fault)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad = 0;

  // Model: mode 0=filling, 1=running, 2=faulted; histories hold accepted samples since reset/recovery.
  int m_mode, m_fill, m_idle, m_th, m_vis;
  int wq[$], tq[$], thq[$], vq[$];
  int e_th, e_wind, e_vis, e_temp, e_ov, e_fault;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  function automatic int fdiv4(input int s);
    return (s >= 0) ? s / 4 : -((-s + 3) / 4);
  endfunction

  task automatic model(input bit rst, input bit sv, input bit th, input int w, input int v, input int t);
    int n, sw, st;
    if (rst) begin
      m_mode = 0; m_fill = 0; m_idle = 0; m_th = 0; m_vis = 0;
      wq.delete(); tq.delete(); thq.delete(); vq.delete();
      e_th = 0; e_wind = 0; e_vis = 0; e_temp = 0; e_ov = 0; e_fault = 0;
      return;
    end
    e_ov = 0;
    if (!sv) begin
      if (m_idle < TO) m_idle++;
      if (m_idle == TO && m_mode != 2) begin
        m_mode = 2;
        e_fault = 1;
      end
      return;
    end
    m_idle = 0;
    if (m_mode == 2) begin
      wq.delete(); tq.delete(); thq.delete(); vq.delete();
      m_fill = 0; m_mode = 0; e_fault = 0;
    end
    wq.push_back(w); tq.push_back(t); thq.push_back(int'(th)); vq.push_back(v);
    if (wq.size() > 4) begin void'(wq.pop_front()); void'(tq.pop_front()); end
    if (thq.size() > 4) begin void'(thq.pop_front()); void'(vq.pop_front()); end
    n = thq.size();
    if (n >= 2 && thq[n-1] == 1 && thq[n-2] == 1) m_th = 1;
    else if (n >= 3 && thq[n-1] == 0 && thq[n-2] == 0 && thq[n-3] == 0) m_th = 0;
    if (n >= 2 && vq[n-1] == vq[n-2]) m_vis = vq[n-1];
    if (m_mode == 0) begin
      m_fill++;
      if (m_fill == 4) m_mode = 1;
      else return;
    end
    sw = 0; st = 0;
    foreach (wq[i]) sw += wq[i];
    foreach (tq[i]) st += tq[i];
    e_wind = sw / 4; e_temp = fdiv4(st); e_th = m_th; e_vis = m_vis; e_ov = 1;
  endtask

  task automatic step(input bit rst, input bit sv, input bit th, input int w, input int v, input int t);
    RST = rst; sample_valid = sv; raw_thunder = th;
    raw_wind = 6'(w); raw_visibility = 2'(v); raw_temperature = 8'(t);
    @(posedge CLK);
    model(rst, sv, th, w, v, t);
    @(negedge CLK);
    chk("out_valid", int'(out_valid), e_ov);
    chk("sensor_fault", int'(sensor_fault), e_fault);
    chk("thunderstorm", int'(thunderstorm), e_th);
    chk("visibility", int'(visibility), e_vis);
    chk("wind", int'(wind), e_wind);
    chk("temperature", int'($signed(temperature)), e_temp);
  endtask

  task automatic samp(input bit th, input int w, input int v, input int t);
    step(1'b0, 1'b1, th, w, v, t);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 0, 0, 0);
  endtask

  initial begin
    // Reset state
    step(1'b1, 1'b0, 1'b0, 0, 0, 0);
    step(1'b1, 1'b1, 1'b1, 5, 3, 9);
    chk("rst_ov", int'(out_valid), 0);
    chk("rst_wind", int'(wind), 0);
    chk("rst_fault", int'(sensor_fault), 0);

    // First publish after 4th sample: wind 12..15 -> 13, temp 30
    samp(0, 12, 0, 30); samp(0, 13, 0, 30); samp(0, 14, 0, 30);
    chk("fill_no_ov", int'(out_valid), 0);
    samp(0, 15, 0, 30);
    chk("first_ov", int'(out_valid), 1);
    chk("first_wind", int'(wind), 13);
    chk("model_wind", e_wind, 13);
    chk("first_temp", int'($signed(temperature)), 30);
    idle(1);
    chk("ov_drop", int'(out_valid), 0);
    chk("wind_hold", int'(wind), 13);

    // Averaging boundaries
    samp(0, 0, 0, -1); samp(0, 0, 0, 0); samp(0, 0, 0, 0); samp(0, 0, 0, 0);
    chk("temp_m1", int'($signed(temperature)), -1);
    chk("model_temp_m1", e_temp, -1);
    for (int i = 0; i < 4; i++) samp(0, 63, 0, -128);
    chk("temp_min", int'($signed(temperature)), -128);
    chk("wind_max", int'(wind), 63);
    for (int i = 0; i < 4; i++) samp(0, (i == 3) ? 62 : 63, 0, 127);
    chk("temp_max", int'($signed(temperature)), 127);
    chk("wind_62", int'(wind), 62);

    // Thunder debounce 1,0,1,1,0,0,1,0,0,0 with idle gaps inside a run
    samp(1, 8, 0, 0); samp(0, 8, 0, 0); samp(1, 8, 0, 0);
    chk("th_3", int'(thunderstorm), 0);
    idle(3);
    samp(1, 8, 0, 0);
    chk("th_4", int'(thunderstorm), 1);
    samp(0, 8, 0, 0); samp(0, 8, 0, 0); samp(1, 8, 0, 0); samp(0, 8, 0, 0); samp(0, 8, 0, 0);
    chk("th_9", int'(thunderstorm), 1);
    samp(0, 8, 0, 0);
    chk("th_10", int'(thunderstorm), 0);

    // Visibility persistence 2,2,1,3,3
    samp(1, 20, 2, 0);
    chk("vis_single", int'(visibility), 0);
    samp(1, 20, 2, 0);
    chk("vis_2", int'(visibility), 2);
    samp(1, 20, 1, 0); samp(1, 20, 3, 0);
    chk("vis_hold", int'(visibility), 2);
    samp(1, 20, 3, 0);
    chk("vis_3", int'(visibility), 3);

    // Stale stream -> fault on 8th idle edge, outputs held
    idle(7);
    chk("fault_7", int'(sensor_fault), 0);
    idle(1);
    chk("fault_8", int'(sensor_fault), 1);
    chk("fault_wind_hold", int'(wind), 20);
    chk("fault_th_hold", int'(thunderstorm), 1);
    idle(2);

    // Recovery refills; filtered values survive the fault
    samp(0, 4, 0, -4);
    chk("recover_fault", int'(sensor_fault), 0);
    chk("recover_no_ov", int'(out_valid), 0);
    samp(1, 8, 1, -4); samp(0, 12, 0, -4);
    chk("recover_3_no_ov", int'(out_valid), 0);
    samp(1, 16, 1, -3);
    chk("recover_ov", int'(out_valid), 1);
    chk("recover_wind", int'(wind), 10);
    chk("recover_temp", int'($signed(temperature)), -4);
    chk("retain_th", int'(thunderstorm), 1);
    chk("retain_vis", int'(visibility), 3);

    // Sample on the would-be timeout cycle wins
    idle(7); samp(0, 1, 0, 1);
    chk("near_to_1", int'(sensor_fault), 0);
    idle(7); samp(0, 1, 0, 1);
    chk("near_to_2", int'(sensor_fault), 0);

    // Reset mid-FILL discards partial window
    step(1'b1, 1'b1, 1'b0, 9, 0, 9);
    samp(0, 2, 0, 2); samp(0, 2, 0, 2); samp(0, 2, 0, 2);
    step(1'b1, 1'b1, 1'b0, 9, 0, 9);
    chk("rst_mid_ov", int'(out_valid), 0);
    samp(0, 5, 0, 5); samp(0, 5, 0, 5); samp(0, 5, 0, 5);
    chk("refill_3_no_ov", int'(out_valid), 0);
    samp(0, 5, 0, 5);
    chk("refill_ov", int'(out_valid), 1);

    // Fault from FILL, then reset overrides it
    step(1'b1, 1'b0, 1'b0, 0, 0, 0);
    idle(8);
    chk("fill_fault", int'(sensor_fault), 1);
    step(1'b1, 1'b1, 1'b1, 7, 1, 7);
    chk("rst_clears_fault", int'(sensor_fault), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
